// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: multi-account ATM session FSM with PIN retry lockout,
// per-session withdrawal cap and MENU inactivity timeout.
// Ports: clk, rst (async active-low); front end: start, acc_num, pin,
//   pin_valid, op, op_valid, amount, new_pin; results: balance, done,
//   success, err_code, busy, txn_count.
// Optional: define ATM_AUDIT_EN for the txn_count counter and err hold.
module atm_session_ctrl #(
    parameter int NUM_ACC     = 16,
    parameter int BAL_W       = 32,
    parameter int PIN_W       = 16,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int WD_LIMIT    = 5000,
    localparam int AW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic             pin_valid,
    input  logic [2:0]       op,
    input  logic             op_valid,
    input  logic [BAL_W-1:0] amount,
    input  logic [PIN_W-1:0] new_pin,
    output logic [BAL_W-1:0] balance,
    output logic             done,
    output logic             success,
    output logic [2:0]       err_code,
    output logic             busy,
    output logic [15:0]      txn_count
);

    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int TMW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] OP_BAL  = 3'd1;
    localparam logic [2:0] OP_WD   = 3'd2;
    localparam logic [2:0] OP_DEP  = 3'd3;
    localparam logic [2:0] OP_CPIN = 3'd4;
    localparam logic [2:0] OP_EXIT = 3'd5;

    localparam logic [2:0] E_OK      = 3'd0;
    localparam logic [2:0] E_BAD_ACC = 3'd1;
    localparam logic [2:0] E_BAD_PIN = 3'd2;
    localparam logic [2:0] E_LOCKED  = 3'd3;
    localparam logic [2:0] E_FUNDS   = 3'd4;
    localparam logic [2:0] E_LIMIT   = 3'd5;
    localparam logic [2:0] E_OVF     = 3'd6;
    localparam logic [2:0] E_TIMEOUT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_AUTH, S_MENU, S_EXEC, S_REPORT
    } state_t;

    state_t state, state_n;

    logic [BAL_W-1:0] bal    [NUM_ACC];
    logic [PIN_W-1:0] pin_db [NUM_ACC];
    logic [NUM_ACC-1:0] lock;

    logic [AW-1:0]    idx;
    logic [TW-1:0]    tries;
    logic [TMW-1:0]   timer;
    logic [BAL_W-1:0] session_wd;
    logic [2:0]       op_q;
    logic [BAL_W-1:0] amt_q;
    logic [PIN_W-1:0] npin_q;

    logic [BAL_W-1:0] cur_bal;
    logic [PIN_W-1:0] cur_pin;
    logic [BAL_W:0]   wd_sum;
    logic [BAL_W:0]   dep_sum;
    logic             acc_bad;

    logic             done_n, succ_n;
    logic [2:0]       err_n;
    logic             bal_we, pin_we, lock_set, sess_ld;
    logic             tries_inc, tries_clr, op_ld, wd_add;
    logic [BAL_W-1:0] bal_new;

    assign cur_bal = bal[idx];
    assign cur_pin = pin_db[idx];
    assign wd_sum  = {1'b0, session_wd} + {1'b0, amt_q};
    assign dep_sum = {1'b0, cur_bal} + {1'b0, amt_q};
    assign acc_bad = {1'b0, acc_num} >= (AW + 1)'(NUM_ACC);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        done_n    = 1'b0;
        succ_n    = 1'b0;
        err_n     = E_OK;
        bal_we    = 1'b0;
        bal_new   = cur_bal;
        pin_we    = 1'b0;
        lock_set  = 1'b0;
        sess_ld   = 1'b0;
        tries_inc = 1'b0;
        tries_clr = 1'b0;
        op_ld     = 1'b0;
        wd_add    = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                if (acc_bad) begin
                    done_n = 1'b1;
                    err_n  = E_BAD_ACC;
                end else if (lock[acc_num]) begin
                    done_n = 1'b1;
                    err_n  = E_LOCKED;
                end else begin
                    sess_ld = 1'b1;
                    state_n = S_AUTH;
                end
            end
            S_AUTH: if (pin_valid) begin
                done_n = 1'b1;
                if (pin == cur_pin) begin
                    succ_n    = 1'b1;
                    tries_clr = 1'b1;
                    state_n   = S_MENU;
                end else if (tries == TW'(MAX_TRIES - 1)) begin
                    lock_set  = 1'b1;
                    tries_clr = 1'b1;
                    err_n     = E_LOCKED;
                    state_n   = S_IDLE;
                end else begin
                    tries_inc = 1'b1;
                    err_n     = E_BAD_PIN;
                end
            end
            S_MENU: begin
                // op_valid takes priority over an expiring timer
                if (op_valid) begin
                    if (op != 3'd0 && op <= OP_EXIT) begin
                        op_ld   = 1'b1;
                        state_n = S_EXEC;
                    end else begin
                        done_n = 1'b1;
                        err_n  = E_BAD_ACC;
                    end
                end else if (timer == TMW'(TIMEOUT_CYC - 1)) begin
                    done_n  = 1'b1;
                    err_n   = E_TIMEOUT;
                    state_n = S_IDLE;
                end
            end
            S_EXEC: begin
                done_n  = 1'b1;
                state_n = S_REPORT;
                unique case (op_q)
                    OP_WD: begin
                        if (amt_q == '0 || amt_q > cur_bal) begin
                            err_n = E_FUNDS;
                        end else if (wd_sum > (BAL_W + 1)'(WD_LIMIT)) begin
                            err_n = E_LIMIT;
                        end else begin
                            succ_n  = 1'b1;
                            bal_we  = 1'b1;
                            bal_new = cur_bal - amt_q;
                            wd_add  = 1'b1;
                        end
                    end
                    OP_DEP: begin
                        if (dep_sum[BAL_W] || amt_q == '0) begin
                            err_n = E_OVF;
                        end else begin
                            succ_n  = 1'b1;
                            bal_we  = 1'b1;
                            bal_new = dep_sum[BAL_W-1:0];
                        end
                    end
                    OP_CPIN: begin
                        if (npin_q == cur_pin) begin
                            err_n = E_BAD_PIN;
                        end else begin
                            succ_n = 1'b1;
                            pin_we = 1'b1;
                        end
                    end
                    OP_BAL: succ_n = 1'b1;
                    OP_EXIT: begin
                        succ_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                    default: err_n = E_BAD_ACC;
                endcase
            end
            S_REPORT: state_n = S_MENU;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                bal[i]    <= BAL_W'((i + 1) * 1000);
                pin_db[i] <= PIN_W'(1000 + i);
            end
            lock       <= '0;
            idx        <= '0;
            tries      <= '0;
            timer      <= '0;
            session_wd <= '0;
            op_q       <= '0;
            amt_q      <= '0;
            npin_q     <= '0;
            balance    <= '0;
            done       <= 1'b0;
            success    <= 1'b0;
            err_code   <= E_OK;
        end else begin
            if (sess_ld) begin
                idx        <= acc_num;
                tries      <= '0;
                session_wd <= '0;
            end
            if (tries_clr) tries <= '0;
            if (tries_inc) tries <= tries + 1'b1;
            if (lock_set)  lock[idx] <= 1'b1;
            if (op_ld) begin
                op_q   <= op;
                amt_q  <= amount;
                npin_q <= new_pin;
            end
            if (bal_we) bal[idx]    <= bal_new;
            if (pin_we) pin_db[idx] <= npin_q;
            if (wd_add) session_wd  <= wd_sum[BAL_W-1:0];
            if (state == S_EXEC) balance <= bal_new;
            timer <= (state == S_MENU && state_n == S_MENU && !op_valid)
                     ? timer + 1'b1 : '0;
            done    <= done_n;
            success <= succ_n;
`ifdef ATM_AUDIT_EN
            // a failed result stays visible one cycle past its done pulse
            err_code <= (!done_n && done && !success) ? err_code : err_n;
`else
            err_code <= err_n;
`endif
        end
    end

`ifdef ATM_AUDIT_EN
    logic [15:0] txn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txn_q <= '0;
        end else if (done_n && succ_n && txn_q != 16'hFFFF) begin
            txn_q <= txn_q + 16'd1;
        end
    end

    assign txn_count = txn_q;
`else
    assign txn_count = 16'd0;
`endif

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed self-checking bench for atm_session_ctrl.
// Drives inputs 1ns after posedge, samples outputs at the same point.
module tb_atm_session_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        pin_valid;
    logic [2:0]  op;
    logic        op_valid;
    logic [31:0] amount;
    logic [15:0] new_pin;
    logic [31:0] balance;
    logic        done;
    logic        success;
    logic [2:0]  err_code;
    logic        busy;
    logic [15:0] txn_count;

    int checks;
    int failures;

    logic        r_d1, r_d, r_s;
    logic [2:0]  r_e;
    logic [31:0] r_b;

    atm_session_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .acc_num(acc_num),
        .pin(pin), .pin_valid(pin_valid), .op(op), .op_valid(op_valid),
        .amount(amount), .new_pin(new_pin), .balance(balance),
        .done(done), .success(success), .err_code(err_code),
        .busy(busy), .txn_count(txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] a);
        acc_num = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_pin(input logic [15:0] p);
        pin = p;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [15:0] np);
        op = o;
        amount = a;
        new_pin = np;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        r_d1 = done;
        tick();
        r_d = done;
        r_s = success;
        r_e = err_code;
        r_b = balance;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (balance !== 32'd0) begin
            failures++;
            $display("FAIL rst_balance got=%0d exp=0", balance);
        end
        checks++;
        if ({done, success, err_code, busy} !== 6'd0) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=000000",
                     {done, success, err_code, busy});
        end
        checks++;
        if (txn_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_txn got=%0d exp=0", txn_count);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_balance();
        do_start(4'd2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL bal_busy got=%b exp=1", busy);
        end
        do_pin(16'd1002);
        checks++;
        if ({done, success, err_code} !== 5'b11_000) begin
            failures++;
            $display("FAIL bal_auth got=%b exp=11000",
                     {done, success, err_code});
        end
        run_op(3'd1, 32'd0, 16'd0);
        checks++;
        if (r_d1 !== 1'b0 || r_d !== 1'b1) begin
            failures++;
            $display("FAIL bal_latency got=%b%b exp=01", r_d1, r_d);
        end
        checks++;
        if (r_b !== 32'd3000 || r_s !== 1'b1) begin
            failures++;
            $display("FAIL bal_value got=%0d/%b exp=3000/1", r_b, r_s);
        end
        run_op(3'd5, 32'd0, 16'd0);
        checks++;
        if (r_d !== 1'b1 || r_s !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bal_exit got=%b%b%b exp=110", r_d, r_s, busy);
        end
    endtask

    task automatic test_withdraw();
        do_start(4'd0);
        do_pin(16'd1000);
        run_op(3'd2, 32'd300, 16'd0);
        checks++;
        if (r_s !== 1'b1 || r_b !== 32'd700) begin
            failures++;
            $display("FAIL wd_ok got=%b/%0d exp=1/700", r_s, r_b);
        end
        run_op(3'd2, 32'd4800, 16'd0);
        checks++;
        if (r_s !== 1'b0 || r_e !== 3'd4) begin
            failures++;
            $display("FAIL wd_funds got=%b/%0d exp=0/4", r_s, r_e);
        end
        checks++;
        if (r_b !== 32'd700) begin
            failures++;
            $display("FAIL wd_funds_bal got=%0d exp=700", r_b);
        end
        run_op(3'd2, 32'd0, 16'd0);
        checks++;
        if (r_e !== 3'd4) begin
            failures++;
            $display("FAIL wd_zero got=%0d exp=4", r_e);
        end
        run_op(3'd5, 32'd0, 16'd0);
    endtask

    task automatic test_limit();
        do_start(4'd9);
        do_pin(16'd1009);
        run_op(3'd2, 32'd3000, 16'd0);
        checks++;
        if (r_s !== 1'b1 || r_b !== 32'd7000) begin
            failures++;
            $display("FAIL lim_first got=%b/%0d exp=1/7000", r_s, r_b);
        end
        run_op(3'd2, 32'd2500, 16'd0);
        checks++;
        if (r_s !== 1'b0 || r_e !== 3'd5 || r_b !== 32'd7000) begin
            failures++;
            $display("FAIL lim_second got=%b/%0d/%0d exp=0/5/7000",
                     r_s, r_e, r_b);
        end
        run_op(3'd2, 32'd2000, 16'd0);
        checks++;
        if (r_s !== 1'b1 || r_b !== 32'd5000) begin
            failures++;
            $display("FAIL lim_exact got=%b/%0d exp=1/5000", r_s, r_b);
        end
        run_op(3'd5, 32'd0, 16'd0);
    endtask

    task automatic test_lockout();
        do_start(4'd5);
        do_pin(16'd1);
        checks++;
        if (done !== 1'b1 || err_code !== 3'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL lock_try1 got=%b/%0d/%b exp=1/2/1",
                     done, err_code, busy);
        end
        do_pin(16'd2);
        checks++;
        if (err_code !== 3'd2) begin
            failures++;
            $display("FAIL lock_try2 got=%0d exp=2", err_code);
        end
        do_pin(16'd3);
        checks++;
        if (done !== 1'b1 || err_code !== 3'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL lock_try3 got=%b/%0d/%b exp=1/3/0",
                     done, err_code, busy);
        end
        tick();
        do_start(4'd5);
        checks++;
        if (done !== 1'b1 || success !== 1'b0 || err_code !== 3'd3) begin
            failures++;
            $display("FAIL lock_restart got=%b%b/%0d exp=10/3",
                     done, success, err_code);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL lock_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_deposit_pin();
        do_start(4'd1);
        do_pin(16'd1001);
        run_op(3'd3, 32'hFFFF_FFFF, 16'd0);
        checks++;
        if (r_s !== 1'b0 || r_e !== 3'd6 || r_b !== 32'd2000) begin
            failures++;
            $display("FAIL dep_ovf got=%b/%0d/%0d exp=0/6/2000",
                     r_s, r_e, r_b);
        end
        run_op(3'd3, 32'd500, 16'd0);
        checks++;
        if (r_s !== 1'b1 || r_b !== 32'd2500) begin
            failures++;
            $display("FAIL dep_ok got=%b/%0d exp=1/2500", r_s, r_b);
        end
        run_op(3'd4, 32'd0, 16'd1001);
        checks++;
        if (r_s !== 1'b0 || r_e !== 3'd2) begin
            failures++;
            $display("FAIL cpin_same got=%b/%0d exp=0/2", r_s, r_e);
        end
        run_op(3'd4, 32'd0, 16'd1234);
        checks++;
        if (r_s !== 1'b1 || r_e !== 3'd0) begin
            failures++;
            $display("FAIL cpin_ok got=%b/%0d exp=1/0", r_s, r_e);
        end
        op = 3'd6;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || success !== 1'b0 || err_code !== 3'd1) begin
            failures++;
            $display("FAIL bad_op got=%b%b/%0d exp=10/1",
                     done, success, err_code);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL bad_op_menu got=%b exp=1", busy);
        end
        tick();
        run_op(3'd5, 32'd0, 16'd0);
        do_start(4'd1);
        do_pin(16'd1001);
        checks++;
        if (success !== 1'b0 || err_code !== 3'd2) begin
            failures++;
            $display("FAIL reauth_old got=%b/%0d exp=0/2", success, err_code);
        end
        do_pin(16'd1234);
        checks++;
        if (done !== 1'b1 || success !== 1'b1) begin
            failures++;
            $display("FAIL reauth_new got=%b%b exp=11", done, success);
        end
        run_op(3'd5, 32'd0, 16'd0);
    endtask

    task automatic test_timeout();
        do_start(4'd3);
        do_pin(16'd1003);
        repeat (1023) tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_early got=%b%b exp=01", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || err_code !== 3'd7 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo_fire got=%b/%0d/%b exp=1/7/0",
                     done, err_code, busy);
        end
        tick();
    endtask

    task automatic test_op_vs_timeout();
        do_start(4'd4);
        do_pin(16'd1004);
        repeat (1023) tick();
        run_op(3'd1, 32'd0, 16'd0);
        checks++;
        if (r_d1 !== 1'b0 || r_d !== 1'b1 || r_s !== 1'b1) begin
            failures++;
            $display("FAIL race_op got=%b%b%b exp=011", r_d1, r_d, r_s);
        end
        checks++;
        if (r_b !== 32'd5000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL race_bal got=%0d/%b exp=5000/1", r_b, busy);
        end
        run_op(3'd5, 32'd0, 16'd0);
    endtask

    task automatic test_reset_mid();
        do_start(4'd0);
        do_pin(16'd1000);
        op = 3'd2;
        amount = 32'd100;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({done, success, err_code, busy} !== 6'd0 ||
            balance !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%0d exp=000000/0",
                     {done, success, err_code, busy}, balance);
        end
        tick();
        rst = 1'b1;
        tick();
        do_start(4'd0);
        do_pin(16'd1000);
        run_op(3'd1, 32'd0, 16'd0);
        checks++;
        if (r_b !== 32'd1000) begin
            failures++;
            $display("FAIL rst_restore got=%0d exp=1000", r_b);
        end
        run_op(3'd5, 32'd0, 16'd0);
        do_start(4'd5);
        do_pin(16'd1005);
        checks++;
        if (done !== 1'b1 || success !== 1'b1) begin
            failures++;
            $display("FAIL rst_unlock got=%b%b exp=11", done, success);
        end
        run_op(3'd5, 32'd0, 16'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        start = 1'b0;
        acc_num = '0;
        pin = '0;
        pin_valid = 1'b0;
        op = '0;
        op_valid = 1'b0;
        amount = '0;
        new_pin = '0;
        test_reset();
        test_balance();
        test_withdraw();
        test_limit();
        test_lockout();
        test_deposit_pin();
        test_timeout();
        test_op_vs_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Parametrised ATM session controller that generalises the single-shot ATM FSM.
- Holds N accounts (balance + PIN) in internal registers and authenticates with a retry counter and per-account lockout.
- Runs multiple operations per session, enforces a per-session withdrawal cap and an inactivity timeout.
- Sits between the card/keypad front end and the display/dispenser logic.

Parameters:
- NUM_ACC, 16, number of accounts; account index width AW = $clog2(NUM_ACC).
- BAL_W, 32, balance/amount width, unsigned.
- PIN_W, 16, PIN width.
- MAX_TRIES, 3, consecutive wrong PINs before the account locks.
- TIMEOUT_CYC, 1024, idle cycles in MENU before forced logout.
- WD_LIMIT, 5000, maximum total withdrawn per session.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  card-insert pulse; sampled only in IDLE.
- acc_num  in  AW  account index; latched on start.
- pin  in  PIN_W  entered PIN; sampled with pin_valid.
- pin_valid  in  1  PIN-entry strobe.
- op  in  3  operation code: 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN, 5 EXIT.
- op_valid  in  1  operation strobe.
- amount  in  BAL_W  withdraw/deposit amount.
- new_pin  in  PIN_W  replacement PIN.
- balance  out  BAL_W  balance of the session account after the last op.
- done  out  1  one-cycle pulse at the end of every op or authentication attempt.
- success  out  1  result qualifier, valid when done=1.
- err_code  out  3  0 OK, 1 BAD_ACC, 2 BAD_PIN, 3 LOCKED, 4 FUNDS, 5 LIMIT, 6 OVERFLOW, 7 TIMEOUT.
- busy  out  1  high whenever the state is not IDLE.
- txn_count  out  16  audit counter (see Optional Feature).

Behaviour:
- Reset (rst=0, async): state IDLE; balance, done, success, err_code, busy, txn_count = 0; tries = 0; all lock bits = 0; session_wd = 0.
- Reset initial values: bal[i] = (i+1)*1000; pin_db[i] = 1000+i.
- A reset mid-session discards the session. Database contents are restored to their reset values.
- IDLE:
  - On start: if acc_num >= NUM_ACC, pulse done with success=0, err=BAD_ACC, stay IDLE.
  - Else if the account's lock bit is set: done, err=LOCKED, stay IDLE.
  - Else latch the index, clear tries and session_wd, go to AUTH.
- AUTH: waits for pin_valid.
  - Match: done, success=1, go to MENU, tries = 0.
  - Mismatch: tries++, done, err=BAD_PIN.
  - If tries reaches MAX_TRIES: set the lock bit, err=LOCKED, go to IDLE. Otherwise stay in AUTH.
- MENU:
  - Timer counts up from 0 each cycle without op_valid. At TIMEOUT_CYC-1: done, err=TIMEOUT, go to IDLE.
  - op_valid latches op/amount/new_pin and goes to EXEC.
  - An invalid op code (0, 6, 7) gives done, success=0, err=BAD_ACC, and stays in MENU.
- EXEC (exactly 1 cycle). Checks are evaluated in the listed order:
  - WITHDRAW fails FUNDS if amount == 0 or amount > bal.
  - WITHDRAW fails LIMIT if session_wd + amount > WD_LIMIT. The sum is computed at BAL_W+1 bits.
  - On WITHDRAW success: bal -= amount; session_wd += amount.
  - DEPOSIT fails OVERFLOW if the BAL_W+1-bit sum carries, or if amount == 0. On failure the balance is unchanged.
  - CHANGE_PIN fails BAD_PIN if new_pin == current PIN; otherwise the PIN is updated.
  - BALANCE always succeeds.
  - EXIT: done, success=1, go to IDLE.
- REPORT: next cycle after EXEC. done=1, balance output updated, return to MENU, timer cleared.
- Latency: op_valid at cycle t gives done at t+2. An authentication result is reported at t+1 after pin_valid.
- Strobe filtering: start is ignored outside IDLE, pin_valid outside AUTH, op_valid outside MENU.
- Simultaneous events: if op_valid arrives in the same cycle the timeout fires, the op wins.
- Lock bits persist across sessions until reset.

Optional Feature:
- Macro: ATM_AUDIT_EN.
- Defined: txn_count increments on every done with success=1 (auth, ops, exit) and saturates at 16'hFFFF. On a failed op, the last err_code is held for one extra cycle.
- Undefined: txn_count is tied to 0, with no counter logic. Outputs are otherwise identical.

Test Plan:
- start, acc 2, pin 1002 -> done, success=1 in MENU; op BALANCE -> balance=3000, done at t+2.
- acc 0, withdraw 300 then 4800 -> first succeeds, balance=700; second fails FUNDS (4800 > 700), balance stays 700.
- acc 9, withdraw 3000 then 2500 -> second fails LIMIT (5500 > 5000), balance=7000.
- acc 5, three wrong PINs -> errs BAD_PIN, BAD_PIN, LOCKED; a new start on acc 5 -> LOCKED immediately.
- acc 1 deposit 32'hFFFFFFFF -> OVERFLOW, balance 2000; CHANGE_PIN 1234 -> success; reauth with 1001 fails, 1234 passes.
- Login then TIMEOUT_CYC idle cycles -> err=TIMEOUT, IDLE; rst asserted mid-EXEC -> all outputs 0 at once, balances restored.
